tile_raster_scheduler: RTL and testbench
========================================

Name: tile_raster_scheduler

Overview:
- Sequences pixel_shader across every screen tile covered by the current triangle's bounding box, in row-major order.
- Hands out tile offsets and ping-pong tile buffer IDs (0/1), so pixel_shader rasterizes one buffer while the tile flush engine writes the other to the framebuffer.
- Sits between the triangle setup stage (box input, frame handshake), pixel_shader (start/done), and the tile flush engine (flush start/done).

Parameters:
- TILE_SHIFT, 3: log2 of tile edge; tile is 8x8.
- SCREEN_W, 640: screen width in pixels.
- SCREEN_H, 480: screen height in pixels.

Ports:
- BOARD_CLK  in  1  system clock; all state updates on its rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse; latches the box and begins a pass. Honoured only in IDLE.
- box_x, box_y, box_w, box_h  in  10 each  bounding box in pixels.
- busy  out  1  high in every state except IDLE.
- frame_done  out  1  one-cycle pulse when the last tile has been flushed.
- raster_start  out  1  one-cycle pulse to pixel_shader.
- raster_done  in  1  one-cycle pulse from pixel_shader.
- raster_tile_id  out  1  buffer pixel_shader writes; stable from raster_start until raster_done.
- tile_offset_x, tile_offset_y  out  10 each  pixel origin of the current tile; same stability as raster_tile_id.
- flush_start  out  1  one-cycle pulse to the flush engine.
- flush_done  in  1  one-cycle pulse from the flush engine.
- flush_tile_id  out  1  buffer being flushed; stable until flush_done.
- flush_offset_x, flush_offset_y  out  10 each  pixel origin of the tile being flushed.

Behaviour:
- Reset: all outputs 0, state IDLE, buf_full[1:0]=0, flush_active=0, next_flush_buf=0, next_raster_buf=0. Reset mid-frame aborts immediately. Pulses already issued are abandoned; raster_done/flush_done arriving after reset are ignored.
- Tile range, computed in SETUP, 1 cycle:
  - tx0 = box_x>>TILE_SHIFT; ty0 = box_y>>TILE_SHIFT.
  - tx1 = min((box_x+box_w-1)>>TILE_SHIFT, SCREEN_W/8-1); ty1 likewise with y and SCREEN_H.
  - Sums use 11-bit arithmetic, with no wrap.
  - Empty box: box_w==0, box_h==0, box_x>=SCREEN_W or box_y>=SCREEN_H. An empty box goes SETUP->DONE, so frame_done fires 2 cycles after frame_start.
- FSM transitions:
  - IDLE -> SETUP on frame_start. The box registers latch at the same time.
  - SETUP -> ISSUE, or -> DONE if the box is empty. Sets cur=(tx0,ty0) and next_raster_buf=0.
  - ISSUE: if buf_full[next_raster_buf]==0 and buffer is not flushing:
    - pulse raster_start;
    - drive offsets = cur<<TILE_SHIFT and raster_tile_id=next_raster_buf;
    - go to WAIT.
    - Otherwise stall in ISSUE with raster_start=0.
  - WAIT: on raster_done:
    - set buf_full[raster_tile_id]; record the tile offset for that buffer;
    - toggle next_raster_buf;
    - go to ADVANCE.
  - ADVANCE:
    - if cur.x<tx1: x+1;
    - else if cur.y<ty1: x=tx0, y+1;
    - else go to DRAIN.
    - Otherwise return to ISSUE.
  - DRAIN: wait until buf_full==0 and flush_active==0, then go to DONE.
  - DONE: pulse frame_done, then go to IDLE.
- Flush channel, running in parallel with the FSM in every state except IDLE:
  - If !flush_active and buf_full[next_flush_buf]:
    - pulse flush_start with that buffer and its recorded offset;
    - set flush_active; toggle next_flush_buf.
  - On flush_done: clear flush_active and clear buf_full[flush_tile_id].
  - A new flush may start the cycle after flush_done.
- Simultaneous events:
  - raster_done and flush_done in the same cycle are both applied.
  - A buffer set full on cycle N is flushable from cycle N+1.
- Ignored inputs:
  - frame_start while busy is ignored.
  - raster_done outside WAIT is ignored.
  - flush_done while !flush_active is ignored.
- Minimum per-tile overhead is 3 cycles plus raster latency: ISSUE, WAIT≥1, ADVANCE.

Test Plan:
- Box (10,10,4,4), instant done responders:
  - one raster_start with offset (8,8) and id 0;
  - one flush_start with (8,8) and id 0;
  - frame_done after flush_done; busy returns to 0.
- Box (0,0,16,16):
  - raster offsets (0,0),(8,0),(0,8),(8,8), with ids 0,1,0,1;
  - flushes occur in the same order;
  - exactly one frame_done.
- Same box, flush_done held off 50 cycles:
  - third raster_start waits until buffer 0 is flushed;
  - raster_start is never issued to a buffer with buf_full set.
- Box (636,476,20,20):
  - clipped to a single tile (632,472);
  - box_w=0 gives frame_done 2 cycles after frame_start, with no raster or flush.
- raster_done and flush_done in the same cycle: both buffer bits update correctly, with no lost flush. A frame_start pulsed mid-frame is ignored.
- RESET_N low during WAIT: all outputs 0 asynchronously; a late raster_done produces no activity; next frame_start runs normally.

Source files
------------

// File: rtl/tile_raster_scheduler.sv
// tile_raster_scheduler: walks the tiles under a bounding box, ping-ponging two tile buffers between pixel_shader and the flush engine
module tile_raster_scheduler #(
  parameter int TILE_SHIFT = 3,
  parameter int SCREEN_W = 640,
  parameter int SCREEN_H = 480
) (
  input  logic       BOARD_CLK,
  input  logic       RESET_N,
  input  logic       frame_start,
  input  logic [9:0] box_x,
  input  logic [9:0] box_y,
  input  logic [9:0] box_w,
  input  logic [9:0] box_h,
  output logic       busy,
  output logic       frame_done,
  output logic       raster_start,
  input  logic       raster_done,
  output logic       raster_tile_id,
  output logic [9:0] tile_offset_x,
  output logic [9:0] tile_offset_y,
  output logic       flush_start,
  input  logic       flush_done,
  output logic       flush_tile_id,
  output logic [9:0] flush_offset_x,
  output logic [9:0] flush_offset_y
);
  localparam logic [9:0] TX_MAX = 10'(SCREEN_W / (1 << TILE_SHIFT) - 1);
  localparam logic [9:0] TY_MAX = 10'(SCREEN_H / (1 << TILE_SHIFT) - 1);
  typedef enum logic [2:0] {IDLE, SETUP, ISSUE, WAIT, ADVANCE, DRAIN, DONE} state_t;
  state_t state;
  logic [9:0] bx, by, bw, bh, cx, cy, tx0, ty0, tx1, ty1;
  logic [10:0] ex, ey;
  logic empty, flush_active, next_flush_buf, next_raster_buf;
  logic [1:0] buf_full;
  logic [19:0] rec_off [2];
  always_comb begin
    ex = ({1'b0, bx} + {1'b0, bw} - 11'd1) >> TILE_SHIFT;
    ey = ({1'b0, by} + {1'b0, bh} - 11'd1) >> TILE_SHIFT;
    tx0 = bx >> TILE_SHIFT;
    ty0 = by >> TILE_SHIFT;
    tx1 = ex > {1'b0, TX_MAX} ? TX_MAX : ex[9:0];
    ty1 = ey > {1'b0, TY_MAX} ? TY_MAX : ey[9:0];
    empty = bw == '0 || bh == '0 || bx >= 10'(SCREEN_W) || by >= 10'(SCREEN_H);
  end
  always_ff @(posedge BOARD_CLK or negedge RESET_N)
    if (!RESET_N) begin
      state <= IDLE;
      busy <= 1'b0;
      frame_done <= 1'b0;
      raster_start <= 1'b0;
      raster_tile_id <= 1'b0;
      tile_offset_x <= '0;
      tile_offset_y <= '0;
      flush_start <= 1'b0;
      flush_tile_id <= 1'b0;
      flush_offset_x <= '0;
      flush_offset_y <= '0;
      bx <= '0;
      by <= '0;
      bw <= '0;
      bh <= '0;
      cx <= '0;
      cy <= '0;
      buf_full <= '0;
      flush_active <= 1'b0;
      next_flush_buf <= 1'b0;
      next_raster_buf <= 1'b0;
      rec_off[0] <= '0;
      rec_off[1] <= '0;
    end else begin
      raster_start <= 1'b0;
      flush_start <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        IDLE: if (frame_start) begin
          bx <= box_x;
          by <= box_y;
          bw <= box_w;
          bh <= box_h;
          busy <= 1'b1;
          state <= SETUP;
        end
        SETUP: begin
          cx <= tx0;
          cy <= ty0;
          next_raster_buf <= 1'b0;
          next_flush_buf <= 1'b0;
          frame_done <= empty;
          state <= empty ? DONE : ISSUE;
        end
        ISSUE: if (!buf_full[next_raster_buf] && !(flush_active && flush_tile_id == next_raster_buf)) begin
          raster_start <= 1'b1;
          raster_tile_id <= next_raster_buf;
          tile_offset_x <= cx << TILE_SHIFT;
          tile_offset_y <= cy << TILE_SHIFT;
          state <= WAIT;
        end
        WAIT: if (raster_done) begin
          buf_full[raster_tile_id] <= 1'b1;
          rec_off[raster_tile_id] <= {tile_offset_x, tile_offset_y};
          next_raster_buf <= ~next_raster_buf;
          state <= ADVANCE;
        end
        ADVANCE: begin
          if (cx < tx1) cx <= cx + 10'd1;
          else if (cy < ty1) begin
            cx <= tx0;
            cy <= cy + 10'd1;
          end
          state <= (cx < tx1 || cy < ty1) ? ISSUE : DRAIN;
        end
        DRAIN: if (buf_full == '0 && !flush_active) begin
          frame_done <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      // flush channel runs alongside the tile walk; a freshly filled buffer is seen one cycle later
      if (state != IDLE) begin
        if (!flush_active && buf_full[next_flush_buf]) begin
          flush_start <= 1'b1;
          flush_tile_id <= next_flush_buf;
          {flush_offset_x, flush_offset_y} <= rec_off[next_flush_buf];
          flush_active <= 1'b1;
          next_flush_buf <= ~next_flush_buf;
        end
        if (flush_done && flush_active) begin
          flush_active <= 1'b0;
          buf_full[flush_tile_id] <= 1'b0;
        end
      end
    end
endmodule

// File: tb/tb_tile_raster_scheduler.sv
// tb_tile_raster_scheduler: drives frames through the scheduler and checks tile order, buffer ids and flush pairing against a tile-list model
module tb_tile_raster_scheduler;
  logic clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
  logic [9:0] box_x = '0, box_y = '0, box_w = '0, box_h = '0;
  logic rd_auto = 1'b0, rd_man = 1'b0, fd_auto = 1'b0, fd_man = 1'b0;
  logic raster_done, flush_done;
  logic busy, frame_done, raster_start, raster_tile_id, flush_start, flush_tile_id;
  logic [9:0] tile_offset_x, tile_offset_y, flush_offset_x, flush_offset_y;
  logic [20:0] rq[$], fq[$], exq[$];
  int rs_cyc[$], fdn_cyc[$];
  int cyc = 0, fd_cyc = 0, st_cyc = 0, fdone_cnt = 0, checks = 0, errors = 0, rlat = 0, flat = 0;
  bit rast_auto = 0, flush_auto = 0;
  logic rpend = 1'b0, fpend = 1'b0, rid = 1'b0, fid = 1'b0;
  logic [1:0] mfull = '0;

  assign raster_done = rd_auto | rd_man;
  assign flush_done = fd_auto | fd_man;

  tile_raster_scheduler dut (
    .BOARD_CLK(clk), .RESET_N(rst_n), .frame_start(frame_start),
    .box_x(box_x), .box_y(box_y), .box_w(box_w), .box_h(box_h),
    .busy(busy), .frame_done(frame_done), .raster_start(raster_start),
    .raster_done(raster_done), .raster_tile_id(raster_tile_id),
    .tile_offset_x(tile_offset_x), .tile_offset_y(tile_offset_y),
    .flush_start(flush_start), .flush_done(flush_done), .flush_tile_id(flush_tile_id),
    .flush_offset_x(flush_offset_x), .flush_offset_y(flush_offset_y)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // observer: logs every start pulse and keeps its own view of which buffers hold unflushed tiles
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      rpend = 1'b0;
      fpend = 1'b0;
      mfull = '0;
    end else begin
      if (raster_start) begin
        rq.push_back({raster_tile_id, tile_offset_x, tile_offset_y});
        rs_cyc.push_back(cyc);
        checks++;
        if (mfull[raster_tile_id]) begin
          errors++;
          $display("FAIL raster_into_full_buffer: id %0d issued while buffers full=%b, required free", raster_tile_id, mfull);
        end
        rid = raster_tile_id;
        rpend = 1'b1;
      end
      if (flush_start) begin
        fq.push_back({flush_tile_id, flush_offset_x, flush_offset_y});
        fid = flush_tile_id;
        fpend = 1'b1;
      end
      if (frame_done) begin
        fdone_cnt++;
        fd_cyc = cyc;
      end
      if (raster_done && rpend) begin
        mfull[rid] = 1'b1;
        rpend = 1'b0;
      end
      if (flush_done && fpend) begin
        mfull[fid] = 1'b0;
        fpend = 1'b0;
        fdn_cyc.push_back(cyc);
      end
    end
  end

  initial forever begin
    @(negedge clk);
    if (raster_start && rast_auto) begin
      repeat (rlat) @(posedge clk);
      @(posedge clk); #1 rd_auto = 1'b1;
      @(posedge clk); #1 rd_auto = 1'b0;
    end
  end

  initial forever begin
    @(negedge clk);
    if (flush_start && flush_auto) begin
      repeat (flat) @(posedge clk);
      @(posedge clk); #1 fd_auto = 1'b1;
      @(posedge clk); #1 fd_auto = 1'b0;
    end
  end

  // expected tile list: row-major walk over the clipped tile rectangle, buffers alternating from 0
  function automatic void exp_tiles(input int x, input int y, input int w, input int h);
    int x1, y1, n = 0;
    logic [20:0] e;
    exq.delete();
    if (w == 0 || h == 0 || x >= 640 || y >= 480) return;
    x1 = (x + w - 1) / 8;
    y1 = (y + h - 1) / 8;
    if (x1 > 79) x1 = 79;
    if (y1 > 59) y1 = 59;
    for (int ty = y / 8; ty <= y1; ty++)
      for (int tx = x / 8; tx <= x1; tx++) begin
        e = {n[0], 10'(tx * 8), 10'(ty * 8)};
        exq.push_back(e);
        n++;
      end
  endfunction

  task automatic start_frame(input int x, input int y, input int w, input int h);
    rq.delete();
    fq.delete();
    rs_cyc.delete();
    fdn_cyc.delete();
    fdone_cnt = 0;
    @(posedge clk); #1;
    box_x = 10'(x);
    box_y = 10'(y);
    box_w = 10'(w);
    box_h = 10'(h);
    frame_start = 1'b1;
    st_cyc = cyc;
    @(posedge clk); #1 frame_start = 1'b0;
  endtask

  task automatic run_frame(input int x, input int y, input int w, input int h, input int rl, input int fl);
    rlat = rl;
    flat = fl;
    rast_auto = 1;
    flush_auto = 1;
    start_frame(x, y, w, h);
    for (int n = 0; n < 5000 && fdone_cnt == 0; n++) begin @(negedge clk); #1; end
    repeat (3) begin @(negedge clk); #1; end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) begin @(negedge clk); #1; end
    checks++;
    if ({busy, frame_done, raster_start, flush_start} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: busy/done/rs/fs=%b, expected 0000", {busy, frame_done, raster_start, flush_start});
    end
    checks++;
    if ({raster_tile_id, tile_offset_x, tile_offset_y} !== 21'b0) begin
      errors++;
      $display("FAIL reset_raster_outs: %h, expected 0", {raster_tile_id, tile_offset_x, tile_offset_y});
    end
    checks++;
    if ({flush_tile_id, flush_offset_x, flush_offset_y} !== 21'b0) begin
      errors++;
      $display("FAIL reset_flush_outs: %h, expected 0", {flush_tile_id, flush_offset_x, flush_offset_y});
    end
    rst_n = 1'b1;
    repeat (3) begin @(negedge clk); #1; end
    checks++;
    if (busy !== 1'b0 || rq.size() != 0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b rasters=%0d, expected 0 and 0", busy, rq.size());
    end
  endtask

  task automatic test_single;
    run_frame(10, 10, 4, 4, 0, 0);
    exp_tiles(10, 10, 4, 4);
    checks++;
    if (rq.size() != exq.size() || fq.size() != exq.size()) begin
      errors++;
      $display("FAIL single_count: raster %0d flush %0d, expected %0d", rq.size(), fq.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < rq.size() && i < fq.size(); i++) begin
      checks++;
      if (rq[i] !== exq[i] || fq[i] !== exq[i]) begin
        errors++;
        $display("FAIL single_tile[%0d]: raster %h flush %h, expected %h", i, rq[i], fq[i], exq[i]);
      end
    end
    checks++;
    if (fdone_cnt != 1 || busy !== 1'b0 || fdn_cyc.size() != 1 || fd_cyc <= fdn_cyc[0]) begin
      errors++;
      $display("FAIL single_done: frame_done count %0d busy %b flush_dones %0d, expected 1 0 1 with done after flush", fdone_cnt, busy, fdn_cyc.size());
    end
  endtask

  task automatic test_quad;
    run_frame(0, 0, 16, 16, 2, 1);
    exp_tiles(0, 0, 16, 16);
    checks++;
    if (rq.size() != exq.size() || fq.size() != exq.size()) begin
      errors++;
      $display("FAIL quad_count: raster %0d flush %0d, expected %0d", rq.size(), fq.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < rq.size() && i < fq.size(); i++) begin
      checks++;
      if (rq[i] !== exq[i] || fq[i] !== exq[i]) begin
        errors++;
        $display("FAIL quad_tile[%0d]: raster %h flush %h, expected %h", i, rq[i], fq[i], exq[i]);
      end
    end
    checks++;
    if (fdone_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL quad_done: frame_done count %0d busy %b, expected 1 0", fdone_cnt, busy);
    end
  endtask

  task automatic test_back_pressure;
    run_frame(0, 0, 16, 16, 0, 50);
    exp_tiles(0, 0, 16, 16);
    checks++;
    if (rq.size() != exq.size() || fq.size() != exq.size()) begin
      errors++;
      $display("FAIL bp_count: raster %0d flush %0d, expected %0d", rq.size(), fq.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < rq.size() && i < fq.size(); i++) begin
      checks++;
      if (rq[i] !== exq[i] || fq[i] !== exq[i]) begin
        errors++;
        $display("FAIL bp_tile[%0d]: raster %h flush %h, expected %h", i, rq[i], fq[i], exq[i]);
      end
    end
    checks++;
    if (rs_cyc.size() < 3 || fdn_cyc.size() < 1 || rs_cyc[2] <= fdn_cyc[0]) begin
      errors++;
      $display("FAIL bp_third_waits: third raster cycle %0d first flush_done cycle %0d, expected later", rs_cyc.size() > 2 ? rs_cyc[2] : -1, fdn_cyc.size() > 0 ? fdn_cyc[0] : -1);
    end
    checks++;
    if (fdone_cnt != 1) begin
      errors++;
      $display("FAIL bp_done: frame_done count %0d, expected 1", fdone_cnt);
    end
  endtask

  task automatic test_clip_and_empty;
    run_frame(636, 476, 20, 20, 1, 0);
    checks++;
    if (rq.size() != 1 || fq.size() != 1 || rq[0] !== {1'b0, 10'd632, 10'd472} || fq[0] !== {1'b0, 10'd632, 10'd472}) begin
      errors++;
      $display("FAIL clip_tile: rasters %0d flushes %0d first %h, expected one tile %h", rq.size(), fq.size(), rq.size() > 0 ? rq[0] : 21'h0, {1'b0, 10'd632, 10'd472});
    end
    run_frame(100, 100, 0, 20, 0, 0);
    checks++;
    if (fdone_cnt != 1 || fd_cyc - st_cyc != 2) begin
      errors++;
      $display("FAIL empty_latency: frame_done count %0d latency %0d, expected 1 and 2", fdone_cnt, fd_cyc - st_cyc);
    end
    checks++;
    if (rq.size() != 0 || fq.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL empty_quiet: rasters %0d flushes %0d busy %b, expected 0 0 0", rq.size(), fq.size(), busy);
    end
  endtask

  task automatic test_simultaneous;
    rast_auto = 0;
    flush_auto = 0;
    start_frame(0, 0, 24, 8);
    for (int n = 0; n < 100 && rq.size() < 1; n++) begin @(negedge clk); #1; end
    @(posedge clk); #1 rd_man = 1'b1;
    @(posedge clk); #1 rd_man = 1'b0;
    for (int n = 0; n < 100 && (rq.size() < 2 || fq.size() < 1); n++) begin @(negedge clk); #1; end
    @(posedge clk); #1;
    rd_man = 1'b1;
    fd_man = 1'b1;
    frame_start = 1'b1;
    box_x = 10'd100;
    @(posedge clk); #1;
    rd_man = 1'b0;
    fd_man = 1'b0;
    frame_start = 1'b0;
    for (int n = 0; n < 100 && (rq.size() < 3 || fq.size() < 2); n++) begin @(negedge clk); #1; end
    @(posedge clk); #1 rd_man = 1'b1; fd_man = 1'b1;
    @(posedge clk); #1 rd_man = 1'b0; fd_man = 1'b0;
    for (int n = 0; n < 100 && fq.size() < 3; n++) begin @(negedge clk); #1; end
    @(posedge clk); #1 fd_man = 1'b1;
    @(posedge clk); #1 fd_man = 1'b0;
    for (int n = 0; n < 100 && fdone_cnt == 0; n++) begin @(negedge clk); #1; end
    repeat (10) begin @(negedge clk); #1; end
    exp_tiles(0, 0, 24, 8);
    checks++;
    if (rq.size() != exq.size() || fq.size() != exq.size()) begin
      errors++;
      $display("FAIL simul_count: raster %0d flush %0d, expected %0d", rq.size(), fq.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < rq.size() && i < fq.size(); i++) begin
      checks++;
      if (rq[i] !== exq[i] || fq[i] !== exq[i]) begin
        errors++;
        $display("FAIL simul_tile[%0d]: raster %h flush %h, expected %h", i, rq[i], fq[i], exq[i]);
      end
    end
    checks++;
    if (fdone_cnt != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL simul_done: frame_done count %0d busy %b, expected 1 0", fdone_cnt, busy);
    end
  endtask

  task automatic test_reset_in_wait;
    rast_auto = 0;
    flush_auto = 1;
    flat = 20;
    start_frame(0, 0, 16, 16);
    for (int n = 0; n < 100 && rq.size() < 1; n++) begin @(negedge clk); #1; end
    @(posedge clk); #1 rd_man = 1'b1;
    @(posedge clk); #1 rd_man = 1'b0;
    for (int n = 0; n < 100 && rq.size() < 2; n++) begin @(negedge clk); #1; end
    checks++;
    if (raster_tile_id !== 1'b1 || tile_offset_x !== 10'd8 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rwait_pre: id %b off_x %0d busy %b, expected 1 8 1", raster_tile_id, tile_offset_x, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, frame_done, raster_start, flush_start, raster_tile_id, tile_offset_x, tile_offset_y, flush_tile_id, flush_offset_x, flush_offset_y} !== 46'b0) begin
      errors++;
      $display("FAIL rwait_async_clear: outputs %h, expected 0", {busy, frame_done, raster_start, flush_start, raster_tile_id, tile_offset_x, tile_offset_y, flush_tile_id, flush_offset_x, flush_offset_y});
    end
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1 rd_man = 1'b1;
    @(posedge clk); #1 rd_man = 1'b0;
    repeat (30) begin @(negedge clk); #1; end
    checks++;
    if (rq.size() != 2 || fq.size() != 1 || busy !== 1'b0 || fdone_cnt != 0) begin
      errors++;
      $display("FAIL rwait_quiet: rasters %0d flushes %0d busy %b done %0d, expected 2 1 0 0", rq.size(), fq.size(), busy, fdone_cnt);
    end
    run_frame(0, 0, 16, 16, 1, 1);
    exp_tiles(0, 0, 16, 16);
    checks++;
    if (rq.size() != exq.size() || fq.size() != exq.size() || fdone_cnt != 1) begin
      errors++;
      $display("FAIL rwait_rerun_count: raster %0d flush %0d done %0d, expected %0d %0d 1", rq.size(), fq.size(), fdone_cnt, exq.size(), exq.size());
    end
    for (int i = 0; i < exq.size() && i < rq.size() && i < fq.size(); i++) begin
      checks++;
      if (rq[i] !== exq[i] || fq[i] !== exq[i]) begin
        errors++;
        $display("FAIL rwait_rerun_tile[%0d]: raster %h flush %h, expected %h", i, rq[i], fq[i], exq[i]);
      end
    end
  endtask

  task automatic test_random;
    int x, y, w, h;
    for (int it = 0; it < 15; it++) begin
      x = int'($urandom_range(0, 700));
      y = int'($urandom_range(0, 520));
      w = int'($urandom_range(0, 40));
      h = int'($urandom_range(0, 40));
      run_frame(x, y, w, h, int'($urandom_range(0, 5)), int'($urandom_range(0, 8)));
      exp_tiles(x, y, w, h);
      checks++;
      if (rq.size() != exq.size() || fq.size() != exq.size() || fdone_cnt != 1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL rand%0d_count box(%0d,%0d,%0d,%0d): raster %0d flush %0d done %0d busy %b, expected %0d %0d 1 0", it, x, y, w, h, rq.size(), fq.size(), fdone_cnt, busy, exq.size(), exq.size());
      end
      for (int i = 0; i < exq.size() && i < rq.size() && i < fq.size(); i++) begin
        checks++;
        if (rq[i] !== exq[i] || fq[i] !== exq[i]) begin
          errors++;
          $display("FAIL rand%0d_tile[%0d]: raster %h flush %h, expected %h", it, i, rq[i], fq[i], exq[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_quad;
    test_back_pressure;
    test_clip_and_empty;
    test_simultaneous;
    test_reset_in_wait;
    test_random;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
